// File: rtl/dual_grant_arbiter.sv
// Registered two-winner arbiter: picks the two highest-priority asserted requests under fixed or
// rotating priority and presents them through a one-entry valid/ready output stage.
module dual_grant_arbiter #(
  parameter int unsigned N_REQ = 12,
  parameter int unsigned MODE  = 0,
  parameter int unsigned IDX_W = $clog2(N_REQ)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [N_REQ-1:0] req_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [IDX_W-1:0] first_o,
  output logic             first_vld_o,
  output logic [IDX_W-1:0] second_o,
  output logic             second_vld_o
);

  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(N_REQ - 1);

  // Step one position down the priority order, wrapping 0 back to N_REQ-1.
  function automatic logic [IDX_W-1:0] dec_wrap(input logic [IDX_W-1:0] idx);
    return (idx == '0) ? LastIdx : idx - IDX_W'(1);
  endfunction

  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic             out_valid_q, out_valid_d;
  logic [IDX_W-1:0] first_q, first_d;
  logic [IDX_W-1:0] second_q, second_d;
  logic             first_vld_q, first_vld_d;
  logic             second_vld_q, second_vld_d;
  logic [IDX_W-1:0] scan_idx;
  logic             accept;
  logic             consume;

  assign in_ready_o = !out_valid_q || out_ready_i;
  assign accept     = in_valid_i && in_ready_o;
  assign consume    = out_valid_q && out_ready_i;

  // Walk the request vector from ptr downwards, keeping the first two hits.
  always_comb begin
    first_d      = '0;
    second_d     = '0;
    first_vld_d  = 1'b0;
    second_vld_d = 1'b0;
    scan_idx     = ptr_q;
    for (int k = 0; k < N_REQ; k++) begin
      if (req_i[scan_idx]) begin
        if (!first_vld_d) begin
          first_d     = scan_idx;
          first_vld_d = 1'b1;
        end else if (!second_vld_d) begin
          second_d     = scan_idx;
          second_vld_d = 1'b1;
        end
      end
      scan_idx = dec_wrap(scan_idx);
    end
  end

  // Rotating mode moves the top priority just below the last winner granted.
  always_comb begin
    ptr_d = ptr_q;
    if (MODE == 1 && accept) begin
      if (second_vld_d) begin
        ptr_d = dec_wrap(second_d);
      end else if (first_vld_d) begin
        ptr_d = dec_wrap(first_d);
      end
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    if (accept) begin
      out_valid_d = 1'b1;
    end else if (consume) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q        <= LastIdx;
      out_valid_q  <= 1'b0;
      first_q      <= '0;
      second_q     <= '0;
      first_vld_q  <= 1'b0;
      second_vld_q <= 1'b0;
    end else begin
      ptr_q       <= ptr_d;
      out_valid_q <= out_valid_d;
      if (accept) begin
        first_q      <= first_d;
        second_q     <= second_d;
        first_vld_q  <= first_vld_d;
        second_vld_q <= second_vld_d;
      end
    end
  end

  assign out_valid_o  = out_valid_q;
  assign first_o      = first_q;
  assign second_o     = second_q;
  assign first_vld_o  = first_vld_q;
  assign second_vld_o = second_vld_q;

endmodule

// File: doc/dual_grant_arbiter.md
Name: dual_grant_arbiter

Overview:
- Registered, parametrised two-winner arbiter: each accepted request vector yields the two highest-priority asserted requests as indices plus per-index valid flags.
- Successor to the combinational dual priority encoder. Adds configurable width, a selectable rotating (round-robin) priority mode, and a valid/ready output stage with back-pressure.
- Sits between request sources and a two-port resource, e.g. a dual-issue DMA or a two-bank memory scheduler.

Parameters:
- N_REQ, 12, number of request lines; legal range 2..64.
- MODE, 0, priority mode: 0 = fixed priority (highest index wins), 1 = round-robin rotating priority.
- IDX_W, $clog2(N_REQ), index width; derived, never overridden.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  req is presented this cycle.
- in_ready  out  1  block accepts req this cycle.
- req  in  N_REQ  request vector; bit i asserted = requester i wants a grant.
- out_valid  out  1  result registers hold an unconsumed result.
- out_ready  in  1  consumer accepts the result this cycle.
- first  out  IDX_W  index of highest-priority asserted request.
- first_vld  out  1  first is meaningful (at least one request was set).
- second  out  IDX_W  index of second-highest-priority asserted request.
- second_vld  out  1  second is meaningful (at least two requests were set).

Behaviour:
- Reset (rst_n low, asynchronous):
  - out_valid=0, first=0, second=0, first_vld=0, second_vld=0.
  - ptr=N_REQ-1.
  - in_ready follows its combinational equation, so it reads 1 during reset.
- Handshake:
  - in_ready = !out_valid || out_ready.
  - Input accepted when in_valid && in_ready.
  - Output consumed when out_valid && out_ready.
  - Latency: exactly 1 cycle from acceptance to out_valid=1.
  - Full throughput: one result per cycle while out_ready=1.
- Output register update rules:
  - On acceptance, the result registers load the new result and out_valid becomes 1.
  - On consume without acceptance, out_valid becomes 0; the data registers hold their last values.
  - While out_valid && !out_ready, all outputs are held stable and req is ignored.
- Priority order:
  - The highest priority is index ptr, then ptr-1, ptr-2, … decrementing and wrapping from 0 to N_REQ-1.
  - first = first asserted bit in this order; second = next asserted bit after first in this order.
- MODE=0:
  - ptr is constant at N_REQ-1, so the highest set index wins.
  - second is the next lower set index.
- MODE=1 pointer update (on each acceptance):
  - Two grants: ptr <= (second-1) mod N_REQ.
  - One grant: ptr <= (first-1) mod N_REQ.
  - No grants: ptr unchanged.
  - Wrap rule: an index of 0 yields ptr=N_REQ-1.
- Empty and single-request vectors:
  - req==0: the result is still produced with out_valid=1, first_vld=0, second_vld=0, first=0, second=0.
  - Exactly one bit set: second_vld=0 and second=0.
- Simultaneous accept and consume: a new result replaces the old one in the same edge and out_valid stays 1.
- Reset mid-operation: any pending result is discarded and ptr returns to N_REQ-1.
- Combinational paths:
  - No combinational path from req to any output.
  - The only comb path is out_ready→in_ready.
- Index width: all index arithmetic is done in IDX_W bits with explicit mod-N_REQ wrap. This matters when N_REQ is not a power of two; indices ≥ N_REQ never appear.

Test Plan:
- Reset then MODE=0, N_REQ=12: req=12'b0000_1010_0100 accepted with out_ready=1 → next cycle out_valid=1, first=7, second=5, first_vld=1, second_vld=1.
- MODE=0: req=0 → first_vld=0, second_vld=0, first=0, second=0. Then req=12'h001 → first=0, first_vld=1, second_vld=0.
- MODE=1, N_REQ=12, req=12'hFFF held over 6 accepts → (first,second) sequence (11,10),(9,8),(7,6),(5,4),(3,2),(1,0), then back to (11,10).
- MODE=1 wrap: req=12'b1000_0000_0001 with ptr=11 → (11,0) and ptr becomes 11. Repeat: req=12'h002 → first=1, ptr becomes 0; next req=12'h801 → first=0, second=11.
- Back-pressure: out_ready=0 for 3 cycles with in_valid=1 and changing req → in_ready=0, outputs frozen, ptr frozen. Raise out_ready → the queued input is accepted that edge and out_valid stays 1 continuously.
- Assert rst_n low asynchronously (mid-cycle) while out_valid=1 in MODE=1 → out_valid drops immediately. After release, req=12'hFFF gives (11,10), proving ptr reset.
